hilo_ctrl: RTL and testbench

- HI/LO register unit directly downstream of the 32x32 unsigned multiplier in the 54-instruction MIPS CPU.
- Accepts MULT/MULTU/MTHI/MTLO/MFHI/MFLO from the execute stage.
- For multiplies: drives the multiplier with operand magnitudes and waits a fixed latency. It then captures the 64-bit product, applies a sign correction for MULT, and writes HI/LO.
- Stalls the pipeline while a multiply is in flight.

---
 rtl/hilo_pkg.sv | 20 ++
 rtl/hilo_ctrl_if.sv | 29 ++
 rtl/hilo_sign_fix.sv | 20 ++
 rtl/hilo_ctrl.sv | 115 +++++++++++
 tb/tb_hilo_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO unit: op codes, FSM states and word width.
package hilo_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;
    localparam logic [2:0] OP_MFHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/hilo_ctrl_if.sv
// Execute-stage and multiplier signals of the HI/LO unit, bundled with master/slave views.
interface hilo_ctrl_if;
    import hilo_pkg::*;

    logic                  op_valid;
    logic [2:0]            op_code;
    logic [WORD_W-1:0]     rs_data;
    logic [WORD_W-1:0]     rt_data;
    logic                  mul_start;
    logic [WORD_W-1:0]     mul_a;
    logic [WORD_W-1:0]     mul_b;
    logic [2*WORD_W-1:0]   prod_in;
    logic                  stall;
    logic [WORD_W-1:0]     rd_data;
    logic                  rd_valid;
    logic [WORD_W-1:0]     hi;
    logic [WORD_W-1:0]     lo;

    modport master (
        output op_valid, op_code, rs_data, rt_data, prod_in,
        input  mul_start, mul_a, mul_b, stall, rd_data, rd_valid, hi, lo
    );

    modport slave (
        input  op_valid, op_code, rs_data, rt_data, prod_in,
        output mul_start, mul_a, mul_b, stall, rd_data, rd_valid, hi, lo
    );

endinterface

// File: rtl/hilo_sign_fix.sv
// Per-lane conditional two's-complement negate. With neg = sign bit it yields the
// magnitude (operand side); with neg = result sign it fixes up the product.
module hilo_sign_fix #(
    parameter int unsigned Width = 32,
    parameter int unsigned Lanes = 1
) (
    input  logic [Lanes*Width-1:0] i_val,
    input  logic [Lanes-1:0]       i_neg,
    output logic [Lanes*Width-1:0] o_val
);

    function automatic logic [Width-1:0] cond_neg(input logic [Width-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    for (genvar g = 0; g < Lanes; g++) begin : g_lane
        assign o_val[g*Width +: Width] = cond_neg(i_val[g*Width +: Width], i_neg[g]);
    end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register unit behind the unsigned multiplier; stalls while a multiply is in flight.
// Define HILO_BYPASS_EN to let MFHI/MFLO read the fixed-up product in the final busy cycle.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1
) (
    input logic        i_clk,
    input logic        i_reset,
    hilo_ctrl_if.slave if_hilo
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MUL_LAT);

    state_e              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [WORD_W-1:0]   r_mul_a, r_mul_b, r_hi, r_lo;
    logic                r_neg;

    logic                w_op_mul, w_signed, w_accept, w_last, w_is_mf, w_op_real;
    logic [2*WORD_W-1:0] w_mag, w_prod_fix;

    assign w_op_mul  = (if_hilo.op_code == OP_MULT) || (if_hilo.op_code == OP_MULTU);
    assign w_signed  = if_hilo.op_valid && (if_hilo.op_code == OP_MULT);
    assign w_accept  = if_hilo.op_valid && w_op_mul && (r_state == ST_IDLE);
    assign w_last    = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1));
    assign w_is_mf   = (if_hilo.op_code == OP_MFHI) || (if_hilo.op_code == OP_MFLO);
    // Code 7 is reserved and behaves as NOP.
    assign w_op_real = (if_hilo.op_code != OP_NOP) && (if_hilo.op_code != 3'd7);

    hilo_sign_fix #(.Width(WORD_W), .Lanes(2)) u_operand_fix (
        .i_val ({if_hilo.rt_data, if_hilo.rs_data}),
        .i_neg ({w_signed & if_hilo.rt_data[WORD_W-1], w_signed & if_hilo.rs_data[WORD_W-1]}),
        .o_val (w_mag)
    );

    hilo_sign_fix #(.Width(2*WORD_W), .Lanes(1)) u_product_fix (
        .i_val (if_hilo.prod_in),
        .i_neg (r_neg),
        .o_val (w_prod_fix)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_BUSY;
            ST_BUSY: if (w_last)   w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        if_hilo.mul_start = (r_state == ST_BUSY) && (r_cnt == LAT);
        if_hilo.stall     = 1'b0;
        if_hilo.rd_valid  = 1'b0;
        if_hilo.rd_data   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (if_hilo.op_valid && w_is_mf) begin
                    if_hilo.rd_valid = 1'b1;
                    if_hilo.rd_data  = (if_hilo.op_code == OP_MFHI) ? r_hi : r_lo;
                end
            end
            ST_BUSY: begin
                if_hilo.stall = if_hilo.op_valid && w_op_real;
`ifdef HILO_BYPASS_EN
                if (w_last && if_hilo.op_valid && w_is_mf) begin
                    if_hilo.stall    = 1'b0;
                    if_hilo.rd_valid = 1'b1;
                    if_hilo.rd_data  = (if_hilo.op_code == OP_MFHI) ?
                                       w_prod_fix[2*WORD_W-1:WORD_W] : w_prod_fix[WORD_W-1:0];
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= LAT;
                r_mul_a <= w_mag[WORD_W-1:0];
                r_mul_b <= w_mag[2*WORD_W-1:WORD_W];
                r_neg   <= w_signed & (if_hilo.rs_data[WORD_W-1] ^ if_hilo.rt_data[WORD_W-1]);
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_last) begin
                {r_hi, r_lo} <= w_prod_fix;
            end else if ((r_state == ST_IDLE) && if_hilo.op_valid) begin
                if (if_hilo.op_code == OP_MTHI) r_hi <= if_hilo.rs_data;
                if (if_hilo.op_code == OP_MTLO) r_lo <= if_hilo.rs_data;
            end
        end
    end

    assign if_hilo.mul_a = r_mul_a;
    assign if_hilo.mul_b = r_mul_b;
    assign if_hilo.hi    = r_hi;
    assign if_hilo.lo    = r_lo;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: three instances at multiplier latencies 1, 4 and 3.
module tb_hilo_ctrl;
    import hilo_pkg::*;

`ifdef HILO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_ctrl_if f1 ();
    hilo_ctrl_if f4 ();
    hilo_ctrl_if f3 ();

    logic        ovr_en;
    logic [63:0] ovr_val;

    // Ideal multiplier: product of the held operands, valid at any latency.
    assign f1.prod_in = {32'b0, f1.mul_a} * {32'b0, f1.mul_b};
    assign f3.prod_in = {32'b0, f3.mul_a} * {32'b0, f3.mul_b};
    assign f4.prod_in = ovr_en ? ovr_val : {32'b0, f4.mul_a} * {32'b0, f4.mul_b};

    hilo_ctrl #(.MUL_LAT(1)) u_dut1 (.i_clk(clk), .i_reset(rst), .if_hilo(f1));
    hilo_ctrl #(.MUL_LAT(4)) u_dut4 (.i_clk(clk), .i_reset(rst), .if_hilo(f4));
    hilo_ctrl #(.MUL_LAT(3)) u_dut3 (.i_clk(clk), .i_reset(rst), .if_hilo(f3));

    int n_vec = 0;
    int n_err = 0;
    int starts;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        f1.op_valid = 1'b0; f1.op_code = OP_NOP; f1.rs_data = '0; f1.rt_data = '0;
        f4.op_valid = 1'b0; f4.op_code = OP_NOP; f4.rs_data = '0; f4.rt_data = '0;
        f3.op_valid = 1'b0; f3.op_code = OP_NOP; f3.rs_data = '0; f3.rt_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ovr_en = 1'b0;
        ovr_val = '0;
        idle_all();
        repeat (2) step();
        @(negedge clk);
        chk("rst_hi", f1.hi, 0);
        chk("rst_lo", f4.lo, 0);
        chk("rst_mul_a", f4.mul_a, 0);
        chk("rst_mul_start", f1.mul_start, 0);
        chk("rst_stall", f4.stall, 0);
        step();
        rst = 1'b0;

        // MFHI/MFLO right after reset read zero combinationally.
        f1.op_valid = 1'b1; f1.op_code = OP_MFHI;
        @(negedge clk);
        chk("mfhi0_data", f1.rd_data, 0);
        chk("mfhi0_valid", f1.rd_valid, 1);
        chk("mfhi0_stall", f1.stall, 0);
        f1.op_code = OP_MFLO;
        #1;
        chk("mflo0_data", f1.rd_data, 0);
        chk("mflo0_valid", f1.rd_valid, 1);

        // MULTU max*max at latency 1.
        step();
        f1.op_code = OP_MULTU; f1.rs_data = 32'hFFFF_FFFF; f1.rt_data = 32'hFFFF_FFFF;
        step();
        f1.op_valid = 1'b0;
        starts = 0;
        @(negedge clk);
        starts += int'(f1.mul_start);
        chk("multu_hi_pre", f1.hi, 0);
        chk("multu_mul_a", f1.mul_a, 64'hFFFF_FFFF);
        step();
        @(negedge clk);
        starts += int'(f1.mul_start);
        chk("multu_hi", f1.hi, 64'hFFFF_FFFE);
        chk("multu_lo", f1.lo, 64'h0000_0001);
        step();
        @(negedge clk);
        starts += int'(f1.mul_start);
        chk("multu_start_cnt", starts, 1);

        // MULT -3*5 at latency 4 with an MFLO pending throughout.
        step();
        f4.op_valid = 1'b1; f4.op_code = OP_MULT;
        f4.rs_data = 32'hFFFF_FFFD; f4.rt_data = 32'd5;
        step();
        f4.op_code = OP_MFLO;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("mult_mul_a", f4.mul_a, 3);
                chk("mult_mul_b", f4.mul_b, 5);
            end
            chk($sformatf("mult_stall%0d", i), f4.stall, (i < 3) ? 1 : {63'b0, !BYPASS});
            chk($sformatf("mult_rdv%0d", i), f4.rd_valid, (i == 3) ? {63'b0, BYPASS} : 0);
            if (i == 3 && BYPASS) chk("mult_byp_data", f4.rd_data, 64'hFFFF_FFF1);
            step();
        end
        @(negedge clk);
        chk("mult_mflo_stall", f4.stall, 0);
        chk("mult_mflo_valid", f4.rd_valid, 1);
        chk("mult_mflo_data", f4.rd_data, 64'hFFFF_FFF1);
        chk("mult_hi", f4.hi, 64'hFFFF_FFFF);

        // MULT most-negative squared.
        step();
        f4.op_code = OP_MULT; f4.rs_data = 32'h8000_0000; f4.rt_data = 32'h8000_0000;
        step();
        f4.op_valid = 1'b0;
        @(negedge clk);
        chk("minint_mul_a", f4.mul_a, 64'h8000_0000);
        repeat (4) step();
        @(negedge clk);
        chk("minint_hi", f4.hi, 64'h4000_0000);
        chk("minint_lo", f4.lo, 0);

        // MTHI then MFHI on the following cycle.
        step();
        f4.op_valid = 1'b1; f4.op_code = OP_MTHI; f4.rs_data = 32'h1234_5678;
        step();
        f4.op_code = OP_MFHI;
        @(negedge clk);
        chk("mthi_mfhi_data", f4.rd_data, 64'h1234_5678);
        chk("mthi_mfhi_valid", f4.rd_valid, 1);

        // Reset in the second busy cycle aborts the multiply.
        step();
        f4.op_code = OP_MULT; f4.rs_data = 32'd2; f4.rt_data = 32'd3;
        step();
        f4.op_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        f4.op_valid = 1'b1; f4.op_code = OP_MFHI;
        @(negedge clk);
        chk("abort_hi", f4.hi, 0);
        chk("abort_lo", f4.lo, 0);
        chk("abort_mul_a", f4.mul_a, 0);
        chk("abort_idle_stall", f4.stall, 0);
        chk("abort_idle_rdv", f4.rd_valid, 1);
        f4.op_valid = 1'b0;
        ovr_en = 1'b1;
        ovr_val = 64'hDEAD_BEEF_CAFE_F00D;
        repeat (5) step();
        @(negedge clk);
        chk("abort_hi_late", f4.hi, 0);
        chk("abort_lo_late", f4.lo, 0);
        ovr_en = 1'b0;

        // MULTU 7*6 at latency 3 with MFLO held from acceptance.
        step();
        f3.op_valid = 1'b1; f3.op_code = OP_MULTU; f3.rs_data = 32'd7; f3.rt_data = 32'd6;
        step();
        f3.op_code = OP_MFLO;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("byp_stall%0d", i), f3.stall, (i < 2) ? 1 : {63'b0, !BYPASS});
            chk($sformatf("byp_rdv%0d", i), f3.rd_valid, (i == 2) ? {63'b0, BYPASS} : 0);
            if (i == 2 && BYPASS) chk("byp_data", f3.rd_data, 64'h2A);
            step();
        end
        @(negedge clk);
        chk("byp_late_valid", f3.rd_valid, 1);
        chk("byp_late_data", f3.rd_data, 64'h2A);
        chk("byp_late_stall", f3.stall, 0);
        idle_all();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
